// File: rtl/reset_control_pkg.sv
// Shared types and sizing helper for the reset controller.
// The optional RESET_CONTROL_BUSY_EN macro adds the reset_busy output port.
package reset_control_pkg;

   typedef enum logic [2:0] {
      POR      = 3'd0,
      IDLE     = 3'd1,
      VALIDATE = 3'd2,
      DELAY    = 3'd3,
      PULSE    = 3'd4,
      LOCKOUT  = 3'd5
   } rc_state_t;

   // Width of the shared down-counter, sized for the largest timing parameter.
   function automatic int rc_cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_control_sync.sv
// N-flop synchronizer with an asynchronous active-low clear to a selectable value.
// Requires N >= 2.
module reset_control_sync #(
   parameter int   N         = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic clr_n,
   input  logic d,
   output logic q
);

   logic [N-1:0] ff_r;

   // Shift chain; the first stage is the only one that can go metastable.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         ff_r <= {N{RESET_VAL}};
      end else begin
         ff_r <= {ff_r[N-2:0], d};
      end
   end

   assign q = ff_r[N-1];

endmodule

// File: rtl/reset_controller.sv
// System reset generator: power-on reset plus a debounced, delayed, lockout-protected button.
// Define RESET_CONTROL_BUSY_EN to add the registered reset_busy output.
module reset_controller
   import reset_control_pkg::*;
#(
   parameter int Reset_Pulse_Length           = 4,
   parameter int Reset_Delay_Cycles           = 8,
   parameter int Press_Validation_Wait_Cycles = 10,
   parameter int Release_Lockout_Cycles       = 20
) (
   input  logic user_clk,
   input  logic por_n,
   input  logic user_rst_n,
   output logic async_rst
`ifdef RESET_CONTROL_BUSY_EN
   ,
   output logic reset_busy
`endif
);

   localparam int CW = rc_cnt_width(Reset_Pulse_Length, Reset_Delay_Cycles,
                                    Press_Validation_Wait_Cycles, Release_Lockout_Cycles);

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] PULSE_LD = CW'(Reset_Pulse_Length);
   localparam logic [CW-1:0] DELAY_LD = CW'(Reset_Delay_Cycles);
   localparam logic [CW-1:0] VAL_LD   = CW'(Press_Validation_Wait_Cycles);
   localparam logic [CW-1:0] LOCK_LD  = CW'(Release_Lockout_Cycles);

   rc_state_t     state_r;
   rc_state_t     state_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_s;
   logic          rst_s;
   logic          btn_sync_s;
   logic          pressed_s;

   reset_control_sync #(
      .N         (2),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (user_clk),
      .clr_n (por_n),
      .d     (user_rst_n),
      .q     (btn_sync_s)
   );

   assign pressed_s = ~btn_sync_s;

   // State, counter and output register; por_n forces the POR behaviour immediately.
   always_ff @(posedge user_clk or negedge por_n) begin
      if (!por_n) begin
         state_r   <= POR;
         cnt_r     <= PULSE_LD;
         async_rst <= 1'b1;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         async_rst <= rst_s;
      end
   end

   // Next-state, counter and output decode; each timed state exits when the counter reads one.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      rst_s   = 1'b0;
      case (state_r)
         POR: begin
            rst_s = 1'b1;
            if (cnt_r == CNT_ONE) begin
               state_s = LOCKOUT;
               cnt_s   = LOCK_LD;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         IDLE: begin
            if (pressed_s) begin
               state_s = VALIDATE;
               cnt_s   = VAL_LD;
            end else begin
               state_s = IDLE;
            end
         end
         VALIDATE: begin
            if (!pressed_s) begin
               state_s = IDLE;
            end else if (cnt_r == CNT_ONE) begin
               state_s = DELAY;
               cnt_s   = DELAY_LD;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         DELAY: begin
            if (cnt_r == CNT_ONE) begin
               state_s = PULSE;
               cnt_s   = PULSE_LD;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         PULSE: begin
            rst_s = 1'b1;
            if (cnt_r == CNT_ONE) begin
               state_s = LOCKOUT;
               cnt_s   = LOCK_LD;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         LOCKOUT: begin
            // Any press restarts the release window, so a held button never re-arms.
            if (pressed_s) begin
               cnt_s = LOCK_LD;
            end else if (cnt_r == CNT_ONE) begin
               state_s = IDLE;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_s = POR;
            cnt_s   = PULSE_LD;
            rst_s   = 1'b1;
         end
      endcase
   end

`ifdef RESET_CONTROL_BUSY_EN
   // Busy flag register: high whenever the controller is not waiting idle.
   always_ff @(posedge user_clk or negedge por_n) begin
      if (!por_n) begin
         reset_busy <= 1'b1;
      end else begin
         reset_busy <= (state_r != IDLE);
      end
   end
`endif

endmodule

// File: tb/tb_reset_controller.sv
// Self-checking bench for reset_controller: directed scenarios plus random button activity,
// checked every cycle against an event/timestamp model of the reset rules.
module tb_reset_controller;

   localparam int PL = 4;
   localparam int RD = 8;
   localparam int PV = 10;
   localparam int RL = 20;

   logic user_clk = 1'b0;
   logic por_n;
   logic user_rst_n;
   logic async_rst;
`ifdef RESET_CONTROL_BUSY_EN
   logic reset_busy;
`endif

   reset_controller dut (
      .user_clk   (user_clk),
      .por_n      (por_n),
      .user_rst_n (user_rst_n),
      .async_rst  (async_rst)
`ifdef RESET_CONTROL_BUSY_EN
      ,
      .reset_busy (reset_busy)
`endif
   );

   always #5 user_clk = ~user_clk;

   int total = 0;
   int bad   = 0;

   // Model: k = edges since por_n release; a pulse is a time window [pulse_at, pulse_at+PL).
   int   k;
   logic raw_hist [0:8191];
   bit   armed;
   int   rel_run;
   int   press_run;
   int   pulse_at;
   int   lock_start;
   logic exp_rst;
   logic exp_busy;

   // Observation bookkeeping
   logic prev_obs;
   int   rises;
   int   hi_cnt;
   int   rise_k;

   task automatic model_reset();
      k          = 0;
      armed      = 1'b0;
      rel_run    = 0;
      press_run  = 0;
      pulse_at   = -1;
      lock_start = PL;
   endtask

   task automatic model_edge(input logic btn);
      logic s;
      raw_hist[k] = btn;
      s = (k >= 2) ? raw_hist[k-2] : 1'b1;
      exp_busy = !(armed && press_run == 0);
      exp_rst  = (k < PL) || (pulse_at >= 0 && k >= pulse_at && k < pulse_at + PL);
      if (armed) begin
         if (!s) begin
            press_run++;
            if (press_run == PV + 1) begin
               pulse_at   = k + RD + 1;
               lock_start = pulse_at + PL;
               armed      = 1'b0;
               rel_run    = 0;
            end
         end else begin
            press_run = 0;
         end
      end else if (k >= lock_start) begin
         rel_run = s ? rel_run + 1 : 0;
         if (rel_run == RL) begin
            armed     = 1'b1;
            press_run = 0;
         end
      end
      k++;
   endtask

   task automatic step(input logic btn);
      user_rst_n = btn;
      @(posedge user_clk);
      model_edge(btn);
      @(negedge user_clk);
      total++;
      assert (async_rst === exp_rst) else begin
         bad++;
         $error("FAIL async_rst k=%0d got=%b exp=%b", k - 1, async_rst, exp_rst);
      end
`ifdef RESET_CONTROL_BUSY_EN
      total++;
      assert (reset_busy === exp_busy) else begin
         bad++;
         $error("FAIL reset_busy k=%0d got=%b exp=%b", k - 1, reset_busy, exp_busy);
      end
`endif
      if (async_rst === 1'b1 && prev_obs === 1'b0) begin
         rises++;
         rise_k = k - 1;
      end
      if (async_rst === 1'b1) hi_cnt++;
      prev_obs = async_rst;
   endtask

   task automatic por_pulse(input int n);
      por_n = 1'b0;
      #1;
      total++;
      assert (async_rst === 1'b1) else begin
         bad++;
         $error("FAIL por_immediate got=%b exp=1", async_rst);
      end
      for (int i = 0; i < n; i++) begin
         @(negedge user_clk);
         total++;
         assert (async_rst === 1'b1) else begin
            bad++;
            $error("FAIL por_hold cyc=%0d got=%b exp=1", i, async_rst);
         end
      end
      por_n = 1'b1;
      model_reset();
      prev_obs = 1'b1;
   endtask

   initial begin
      int press_k;
      por_n      = 1'b1;
      user_rst_n = 1'b1;
      rises      = 0;
      hi_cnt     = 0;
      rise_k     = -1;
      prev_obs   = 1'b1;
      model_reset();
      #2;

      // 1: power-on reset, button idle; POR pulse then lockout to idle
      por_pulse(8);
      hi_cnt = 0;
      repeat (30) step(1'b1);
      total++;
      assert (hi_cnt === PL) else begin
         bad++;
         $error("FAIL por_len got=%0d exp=%0d", hi_cnt, PL);
      end

      // 2: valid press from idle, 21-cycle latency, single 4-cycle pulse
      rises = 0; hi_cnt = 0; press_k = k;
      repeat (31) step(1'b0);
      repeat (20) step(1'b1);
      total++;
      assert (rises === 1) else begin
         bad++;
         $error("FAIL press_rises got=%0d exp=1", rises);
      end
      total++;
      assert (rise_k - press_k === 21) else begin
         bad++;
         $error("FAIL press_latency got=%0d exp=21", rise_k - press_k);
      end
      total++;
      assert (hi_cnt === PL) else begin
         bad++;
         $error("FAIL press_width got=%0d exp=%0d", hi_cnt, PL);
      end

      // 3: short glitch is rejected
      repeat (10) step(1'b1);
      rises = 0;
      repeat (5) step(1'b0);
      repeat (40) step(1'b1);
      total++;
      assert (rises === 0) else begin
         bad++;
         $error("FAIL glitch_rises got=%0d exp=0", rises);
      end

      // 4: held button gives one pulse; a press inside lockout is ignored, a later one accepted
      rises = 0; hi_cnt = 0;
      repeat (200) step(1'b0);
      total++;
      assert (rises === 1 && hi_cnt === PL) else begin
         bad++;
         $error("FAIL hold_pulse got=%0d/%0d exp=1/%0d", rises, hi_cnt, PL);
      end
      rises = 0;
      repeat (15) step(1'b1);
      repeat (15) step(1'b0);
      repeat (40) step(1'b1);
      repeat (15) step(1'b0);
      repeat (40) step(1'b1);
      total++;
      assert (rises === 1) else begin
         bad++;
         $error("FAIL lockout_rearm got=%0d exp=1", rises);
      end

      // 5: a one-cycle blip during lockout restarts the release window
      repeat (30) step(1'b0);
      repeat (10) step(1'b1);
      rises = 0;
      step(1'b0);
      repeat (12) step(1'b1);
      repeat (12) step(1'b0);
      repeat (40) step(1'b1);
      total++;
      assert (rises === 0) else begin
         bad++;
         $error("FAIL lockout_restart got=%0d exp=0", rises);
      end
      repeat (15) step(1'b0);
      repeat (40) step(1'b1);
      total++;
      assert (rises === 1) else begin
         bad++;
         $error("FAIL after_lockout got=%0d exp=1", rises);
      end

      // 6: por_n during a pulse, button still held: POR pulse only, no extra pulse
      rises = 0;
      for (int i = 0; i < 40 && rises == 0; i++) step(1'b0);
      total++;
      assert (rises === 1) else begin
         bad++;
         $error("FAIL pulse_before_por got=%0d exp=1", rises);
      end
      step(1'b0);
      por_pulse(3);
      rises = 0; hi_cnt = 0;
      repeat (30) step(1'b0);
      repeat (40) step(1'b1);
      total++;
      assert (rises === 0 && hi_cnt === PL) else begin
         bad++;
         $error("FAIL por_mid_pulse got=%0d/%0d exp=0/%0d", rises, hi_cnt, PL);
      end

      // Random button activity with one random power-on reset in the middle
      for (int s = 0; s < 24; s++) begin
         int   n;
         logic b;
         n = $urandom_range(1, 30);
         b = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
         repeat (n) step(b);
         if (s == 12) por_pulse($urandom_range(1, 4));
      end
      repeat (60) step(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
